conv_line_ctrl: RTL and testbench



---
 rtl/conv_ctrl_pkg.sv | 19 +
 rtl/edge_det.sv | 29 ++
 rtl/conv_line_ctrl.sv | 263 ++++++++++++++++++++++++++
 tb/tb_conv_line_ctrl.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_ctrl_pkg.sv
// conv_ctrl_pkg: shared constants for the convolution line controller.
//   - FSM state encoding (plain localparams so older tools can consume it)
//   - default vertical tap count, minimum lockable line period, miss limit
package conv_ctrl_pkg;

  // Line-lock FSM states
  localparam logic [1:0] StSearch  = 2'd0;
  localparam logic [1:0] StMeasure = 2'd1;
  localparam logic [1:0] StCheck   = 2'd2;
  localparam logic [1:0] StLocked  = 2'd3;

  // Number of line taps (vertical kernel size)
  localparam int unsigned TAPS       = 5;
  // Shortest line period (clocks) accepted for lock
  localparam int unsigned MIN_PERIOD = 16;
  // Consecutive period mismatches that drop lock
  localparam int unsigned MISS_LIMIT = 2;

endpackage

// File: rtl/edge_det.sv
// edge_det: registered rising-edge detector.
//   clk_i   - clock
//   rst_ni  - asynchronous active-low reset
//   d_i     - level input (already synchronous to clk_i)
//   rise_o  - high in the cycle where d_i is 1 and was 0 on the previous clock
module edge_det (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic rise_o
);

  logic lvl_q, lvl_d;

  always_comb begin
    lvl_d = d_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lvl_q <= 1'b0;
    end else begin
      lvl_q <= lvl_d;
    end
  end

  assign rise_o = d_i & ~lvl_q;

endmodule

// File: rtl/conv_line_ctrl.sv
// conv_line_ctrl: timing controller for the 5-line convolution filter datapath.
// Locks to the incoming line period, drives the cyclic line-buffer address,
// counts lines per frame and latches the kernel select once per frame.
// Ports:
//   clk        - pixel clock
//   rst        - asynchronous active-low reset
//   sw         - raw kernel-select switches
//   rx_hs      - incoming hsync
//   rx_vs      - incoming vsync
//   rx_dv      - incoming data valid
//   addr       - line-buffer BRAM address (runs 0..period-1 while locked)
//   addr_wrap  - high when addr == period-1
//   line_cnt   - lines since the last vsync rising edge
//   win_valid  - filter window valid (all taps hold image lines, 1 clk after rx_dv)
//   kern_sel   - kernel select, loaded from sw on vsync rise
//   kern_upd   - 1-cycle pulse coinciding with a kern_sel load
//   locked     - high in the LOCKED state
//   period     - stored line period in clocks
//   err_period - 1-cycle pulse on a period mismatch while locked
// All outputs are registered.
module conv_line_ctrl
  import conv_ctrl_pkg::StSearch, conv_ctrl_pkg::StMeasure;
  import conv_ctrl_pkg::StCheck, conv_ctrl_pkg::StLocked;
#(
  parameter int unsigned ADDR_W     = 12,
  parameter int unsigned LINE_W     = 11,
  parameter int unsigned TAPS       = conv_ctrl_pkg::TAPS,
  parameter int unsigned MIN_PERIOD = conv_ctrl_pkg::MIN_PERIOD,
  parameter int unsigned MISS_LIMIT = conv_ctrl_pkg::MISS_LIMIT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        sw,
  input  logic              rx_hs,
  input  logic              rx_vs,
  input  logic              rx_dv,
  output logic [ADDR_W-1:0] addr,
  output logic              addr_wrap,
  output logic [LINE_W-1:0] line_cnt,
  output logic              win_valid,
  output logic [7:0]        kern_sel,
  output logic              kern_upd,
  output logic              locked,
  output logic [ADDR_W-1:0] period,
  output logic              err_period
);

  localparam int unsigned MissW = $clog2(MISS_LIMIT + 1);
  localparam logic [ADDR_W-1:0] PcntMax = '1;

  // ---------------------------------------------------------------------------
  // Edge detection
  // ---------------------------------------------------------------------------
  logic hs_rise, vs_rise;

  edge_det u_hs_edge (
    .clk_i  (clk),
    .rst_ni (rst),
    .d_i    (rx_hs),
    .rise_o (hs_rise)
  );

  edge_det u_vs_edge (
    .clk_i  (clk),
    .rst_ni (rst),
    .d_i    (rx_vs),
    .rise_o (vs_rise)
  );

  // ---------------------------------------------------------------------------
  // Period counter
  // ---------------------------------------------------------------------------
  logic [ADDR_W-1:0] pcnt_q, pcnt_d;
  logic [ADDR_W-1:0] meas;
  logic              pcnt_sat;

  always_comb begin
    pcnt_sat = (pcnt_q == PcntMax);
    // Clocks from the previous hs_rise up to and including this one
    meas     = pcnt_q + ADDR_W'(1);
    if (hs_rise) begin
      pcnt_d = '0;
    end else if (pcnt_sat) begin
      pcnt_d = pcnt_q;
    end else begin
      pcnt_d = pcnt_q + ADDR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pcnt_q <= '0;
    end else begin
      pcnt_q <= pcnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Lock FSM, stored period, miss counter, mismatch pulse
  // ---------------------------------------------------------------------------
  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] period_q, period_d;
  logic [MissW-1:0]  miss_q, miss_d;
  logic              err_period_q, err_period_d;
  logic              locked_q, locked_d;

  always_comb begin
    state_d      = state_q;
    period_d     = period_q;
    miss_d       = miss_q;
    err_period_d = 1'b0;
    // A lost line (counter saturated) drops back to SEARCH. In SEARCH itself the
    // saturated count is harmless, so the next hs_rise still starts a measurement.
    if (pcnt_sat && (state_q != StSearch)) begin
      state_d = StSearch;
      miss_d  = '0;
    end else if (hs_rise) begin
      unique case (state_q)
        StSearch: begin
          state_d = StMeasure;
        end
        StMeasure: begin
          period_d = meas;
          state_d  = StCheck;
        end
        StCheck: begin
          if ((meas == period_q) && (meas >= ADDR_W'(MIN_PERIOD))) begin
            state_d = StLocked;
            miss_d  = '0;
          end else begin
            period_d = meas;
          end
        end
        StLocked: begin
          if (meas == period_q) begin
            miss_d = '0;
          end else begin
            err_period_d = 1'b1;
            if ((miss_q + MissW'(1)) >= MissW'(MISS_LIMIT)) begin
              state_d  = StCheck;
              period_d = meas;
              miss_d   = '0;
            end else begin
              miss_d = miss_q + MissW'(1);
            end
          end
        end
        default: begin
          state_d = StSearch;
        end
      endcase
    end
    locked_d = (state_d == StLocked);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= StSearch;
      period_q     <= '0;
      miss_q       <= '0;
      err_period_q <= 1'b0;
      locked_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      period_q     <= period_d;
      miss_q       <= miss_d;
      err_period_q <= err_period_d;
      locked_q     <= locked_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Line-buffer address and wrap flag
  // ---------------------------------------------------------------------------
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              addr_wrap_q, addr_wrap_d;

  always_comb begin
    if (!locked_d || hs_rise) begin
      addr_d = '0;
    end else if (addr_q == (period_q - ADDR_W'(1))) begin
      // Free-running wrap keeps the buffer cycling even if an hs edge is late
      addr_d = '0;
    end else begin
      addr_d = addr_q + ADDR_W'(1);
    end
    // Look ahead on next-state values so the flag lines up with addr itself
    addr_wrap_d = locked_d && (addr_d == (period_d - ADDR_W'(1)));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q      <= '0;
      addr_wrap_q <= 1'b0;
    end else begin
      addr_q      <= addr_d;
      addr_wrap_q <= addr_wrap_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Line counter and window valid
  // ---------------------------------------------------------------------------
  logic [LINE_W-1:0] line_cnt_q, line_cnt_d;
  logic              win_valid_q, win_valid_d;

  always_comb begin
    // vsync clear wins over a coincident hsync increment
    if (vs_rise) begin
      line_cnt_d = '0;
    end else if (hs_rise && (line_cnt_q != '1)) begin
      line_cnt_d = line_cnt_q + LINE_W'(1);
    end else begin
      line_cnt_d = line_cnt_q;
    end
    win_valid_d = locked_q && (line_cnt_q >= LINE_W'(TAPS - 1)) && rx_dv;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      line_cnt_q  <= '0;
      win_valid_q <= 1'b0;
    end else begin
      line_cnt_q  <= line_cnt_d;
      win_valid_q <= win_valid_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Kernel select, sampled only at frame start
  // ---------------------------------------------------------------------------
  logic [7:0] kern_sel_q, kern_sel_d;
  logic       kern_upd_q, kern_upd_d;

  always_comb begin
    kern_sel_d = vs_rise ? sw : kern_sel_q;
    kern_upd_d = vs_rise;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      kern_sel_q <= '0;
      kern_upd_q <= 1'b0;
    end else begin
      kern_sel_q <= kern_sel_d;
      kern_upd_q <= kern_upd_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign addr       = addr_q;
  assign addr_wrap  = addr_wrap_q;
  assign line_cnt   = line_cnt_q;
  assign win_valid  = win_valid_q;
  assign kern_sel   = kern_sel_q;
  assign kern_upd   = kern_upd_q;
  assign locked     = locked_q;
  assign period     = period_q;
  assign err_period = err_period_q;

endmodule

// File: tb/tb_conv_line_ctrl.sv
// Directed bench for conv_line_ctrl. Inputs change on the falling clock edge and
// outputs are observed on the falling edge, i.e. half a cycle after each update.
module tb_conv_line_ctrl;

  logic        clk;
  logic        rst;
  logic [7:0]  sw;
  logic        rx_hs, rx_vs, rx_dv;
  logic [11:0] addr;
  logic        addr_wrap;
  logic [10:0] line_cnt;
  logic        win_valid;
  logic [7:0]  kern_sel;
  logic        kern_upd;
  logic        locked;
  logic [11:0] period;
  logic        err_period;

  conv_line_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .sw         (sw),
    .rx_hs      (rx_hs),
    .rx_vs      (rx_vs),
    .rx_dv      (rx_dv),
    .addr       (addr),
    .addr_wrap  (addr_wrap),
    .line_cnt   (line_cnt),
    .win_valid  (win_valid),
    .kern_sel   (kern_sel),
    .kern_upd   (kern_upd),
    .locked     (locked),
    .period     (period),
    .err_period (err_period)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned checks   = 0;
  int unsigned failures = 0;

  // Per-line observations collected by run_line
  int unsigned first_addr, last_addr, wrap_cnt, wrap_addr;
  int unsigned err_cnt, upd_cnt, first_lcnt, last_lcnt;
  int unsigned cum_locked, cum_addr_nz;
  logic        first_locked;
  logic [127:0] wv;
  logic        dv_en  = 1'b0;
  int          dv_gap = -1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One line of n clocks: hsync high for the first 4, optional 4-clock vsync
  // pulse starting at vs_at. Must be called right after a falling edge.
  task automatic run_line(input int n, input int vs_at);
    wrap_cnt = 0;
    err_cnt  = 0;
    upd_cnt  = 0;
    wv       = '0;
    for (int i = 0; i < n; i++) begin
      rx_hs = (i < 4);
      rx_vs = (vs_at >= 0) && (i >= vs_at) && (i < vs_at + 4);
      rx_dv = dv_en && (i != dv_gap);
      @(negedge clk);
      if (i == 0) begin
        first_addr   = addr;
        first_locked = locked;
        first_lcnt   = line_cnt;
      end
      if (addr_wrap) begin
        wrap_cnt++;
        wrap_addr = addr;
      end
      if (err_period) err_cnt++;
      if (kern_upd) upd_cnt++;
      if (locked) cum_locked++;
      if (addr != 0) cum_addr_nz++;
      if (i < 128) wv[i] = win_valid;
    end
    last_addr = addr;
    last_lcnt = line_cnt;
  endtask

  initial begin
    rst   = 1'b0;
    sw    = 8'h00;
    rx_hs = 1'b0;
    rx_vs = 1'b0;
    rx_dv = 1'b0;
    repeat (2) @(negedge clk);

    // Reset state
    chk("rst_addr", addr, 0);
    chk("rst_wrap", addr_wrap, 0);
    chk("rst_line_cnt", line_cnt, 0);
    chk("rst_win_valid", win_valid, 0);
    chk("rst_kern_sel", kern_sel, 0);
    chk("rst_kern_upd", kern_upd, 0);
    chk("rst_locked", locked, 0);
    chk("rst_period", period, 0);
    chk("rst_err", err_period, 0);
    rst = 1'b1;

    // 1: lock at period 100
    run_line(100, -1);
    run_line(100, -1);
    chk("t1_unlocked_after_2", locked, 0);
    chk("t1_period_meas", period, 100);
    run_line(100, -1);
    chk("t1_locked_3rd_edge", first_locked, 1);
    chk("t1_addr_start", first_addr, 0);
    chk("t1_addr_end", last_addr, 99);
    chk("t1_wrap_cnt", wrap_cnt, 1);
    chk("t1_wrap_addr", wrap_addr, 99);
    run_line(100, -1);
    chk("t1_no_err", err_cnt, 0);
    chk("t1_still_locked", locked, 1);

    // 2: single long line tolerated, two in a row drop lock
    run_line(101, -1);
    chk("t2_free_wrap_addr", last_addr, 0);
    chk("t2_free_wrap_cnt", wrap_cnt, 1);
    run_line(100, -1);
    chk("t2_err_single", err_cnt, 1);
    chk("t2_locked_kept", locked, 1);
    chk("t2_period_kept", period, 100);
    run_line(100, -1);
    chk("t2_err_cleared", err_cnt, 0);
    run_line(101, -1);
    run_line(101, -1);
    chk("t2_err_first_miss", err_cnt, 1);
    chk("t2_locked_first_miss", locked, 1);
    run_line(100, -1);
    chk("t2_err_second_miss", err_cnt, 1);
    chk("t2_unlocked", locked, 0);
    chk("t2_period_new", period, 101);
    chk("t2_addr_unlocked", addr, 0);

    // 3: relock at 100, then lose hsync until the period counter saturates
    run_line(100, -1);
    run_line(100, -1);
    chk("t3_relocked", first_locked, 1);
    chk("t3_period", period, 100);
    repeat (3996) @(negedge clk);
    chk("t3_locked_pre_sat", locked, 1);
    chk("t3_addr_pre_sat", addr, 95);
    @(negedge clk);
    chk("t3_unlocked_sat", locked, 0);
    chk("t3_addr_sat", addr, 0);
    run_line(100, -1);
    run_line(100, -1);
    chk("t3_unlocked_2_edges", locked, 0);
    chk("t3_period_remeas", period, 100);
    run_line(100, -1);
    chk("t3_locked_3_edges", first_locked, 1);

    // 4: line counting and window valid
    dv_en = 1'b1;
    run_line(100, 50);
    chk("t4_vs_clear", last_lcnt, 0);
    chk("t4_vs_upd", upd_cnt, 1);
    run_line(100, -1);
    chk("t4_lcnt1", first_lcnt, 1);
    run_line(100, -1);
    chk("t4_lcnt2", first_lcnt, 2);
    run_line(100, -1);
    chk("t4_lcnt3", first_lcnt, 3);
    chk("t4_win_off_lcnt3", wv[99], 0);
    run_line(100, -1);
    chk("t4_lcnt4", first_lcnt, 4);
    chk("t4_win_edge_clk", wv[0], 0);
    chk("t4_win_next_clk", wv[1], 1);
    run_line(100, -1);
    chk("t4_lcnt5", first_lcnt, 5);
    chk("t4_win_lcnt5", wv[0], 1);
    dv_gap = 10;
    run_line(100, -1);
    dv_gap = -1;
    chk("t4_lcnt6", first_lcnt, 6);
    chk("t4_win_before_gap", wv[9], 1);
    chk("t4_win_gap", wv[10], 0);
    chk("t4_win_after_gap", wv[11], 1);
    run_line(100, 0);
    chk("t4_vs_hs_same", first_lcnt, 0);
    run_line(100, -1);
    chk("t4_after_same", first_lcnt, 1);

    // 5: kernel select only loads on vsync
    sw = 8'h3C;
    run_line(100, -1);
    chk("t5_kern_hold", kern_sel, 8'h00);
    chk("t5_no_upd", upd_cnt, 0);
    run_line(100, 30);
    chk("t5_kern_load", kern_sel, 8'h3C);
    chk("t5_upd_once", upd_cnt, 1);
    sw = 8'hA5;
    run_line(100, -1);
    chk("t5_kern_ignore", kern_sel, 8'h3C);

    // 6: period below the lock minimum, then asynchronous reset mid-line
    repeat (3) run_line(8, -1);
    cum_locked  = 0;
    cum_addr_nz = 0;
    repeat (7) run_line(8, -1);
    chk("t6_never_locked", cum_locked, 0);
    chk("t6_addr_zero", cum_addr_nz, 0);
    chk("t6_period", period, 8);
    chk("t6_locked", locked, 0);
    rx_hs = 1'b1;
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("t6_async_locked", locked, 0);
    chk("t6_async_period", period, 0);
    chk("t6_async_line_cnt", line_cnt, 0);
    chk("t6_async_kern_sel", kern_sel, 0);
    chk("t6_async_addr", addr, 0);
    chk("t6_async_wrap", addr_wrap, 0);
    chk("t6_async_win", win_valid, 0);
    chk("t6_async_err", err_period, 0);
    chk("t6_async_upd", kern_upd, 0);
    @(negedge clk);
    rx_hs = 1'b0;
    rst   = 1'b1;
    run_line(100, -1);
    run_line(100, -1);
    chk("t6_post_rst_unlocked", locked, 0);
    run_line(100, -1);
    chk("t6_post_rst_locked", first_locked, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
